// File: rtl/serial_add_sched_if.sv
// Request/operand/result bundle between two client requesters and the
// shared bit-serial adder scheduler.
interface serial_add_sched_if #(
  parameter int WIDTH = 8
);
  logic             req0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic             cin0;
  logic             req1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             cin1;
  logic             gnt0;
  logic             gnt1;
  logic             busy;
  logic             done;
  logic             done_id;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output req0, a0, b0, cin0, req1, a1, b1, cin1,
    input  gnt0, gnt1, busy, done, done_id, sum, cout
  );

  modport slave (
    input  req0, a0, b0, cin0, req1, a1, b1, cin1,
    output gnt0, gnt1, busy, done, done_id, sum, cout
  );
endinterface

// File: rtl/serial_add_sched.sv
// Round-robin scheduler sharing one 1-bit full-adder cell between two
// requesters; operands are added LSB first, one bit per clock.
module fullAdder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_sched #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_add_sched_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, ps, sum_r;
  logic [CNT_W-1:0] cnt;
  logic             cr, owner, rr_ptr, cout_r, done_id_r;
  logic             any_req, winner, last_bit;
  logic             fa_s, fa_co;

  fullAdder u_fa (
    .a  (sa[0]),
    .b  (sb[0]),
    .ci (cr),
    .s  (fa_s),
    .co (fa_co)
  );

  assign any_req  = bus.req0 | bus.req1;
  // A lone requester wins outright; on contention the pointer decides.
  assign winner   = (bus.req0 & bus.req1) ? rr_ptr : bus.req1;
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req)  state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // cnt is zero only in the first RUN cycle, so that cycle is the grant pulse.
  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = (state == DONE);
    bus.gnt0 = (state == RUN) && (cnt == '0) && !owner;
    bus.gnt1 = (state == RUN) && (cnt == '0) && owner;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa        <= '0;
      sb        <= '0;
      ps        <= '0;
      cr        <= 1'b0;
      cnt       <= '0;
      owner     <= 1'b0;
      rr_ptr    <= 1'b0;
      sum_r     <= '0;
      cout_r    <= 1'b0;
      done_id_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            sa    <= winner ? bus.a1 : bus.a0;
            sb    <= winner ? bus.b1 : bus.b0;
            cr    <= winner ? bus.cin1 : bus.cin0;
            cnt   <= '0;
            owner <= winner;
          end
        end
        RUN: begin
          ps  <= {fa_s, ps[WIDTH-1:1]};
          cr  <= fa_co;
          sa  <= sa >> 1;
          sb  <= sb >> 1;
          cnt <= cnt + 1'b1;
          if (last_bit) begin
            sum_r     <= {fa_s, ps[WIDTH-1:1]};
            cout_r    <= fa_co;
            done_id_r <= owner;
            rr_ptr    <= ~owner;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sum     = sum_r;
  assign bus.cout    = cout_r;
  assign bus.done_id = done_id_r;
endmodule

// File: tb/tb_serial_add_sched.sv
// Directed-vector bench for serial_add_sched with a queue scoreboard and an
// independent monitor that checks every done pulse.
module tb_serial_add_sched;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_add_sched_if #(.WIDTH(W)) bus ();
  serial_add_sched #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [W+1:0] q[$];   // {done_id, cout, sum}

  int   gnt_cyc   = 0;
  int   last_done = -1;
  bit   spacing_on = 0;
  logic prev_gnt  = 1'b0;

  logic [W-1:0] va[4], vb[4];
  logic         vc[4];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: checks grants and pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.gnt0 | bus.gnt1) begin
        total++;
        if (prev_gnt) begin
          bad++;
          $display("FAIL gnt_pulse: gnt high two cycles in a row, required one-cycle pulse");
        end
        gnt_cyc = cyc;
      end
      prev_gnt = bus.gnt0 | bus.gnt1;
      if (bus.done) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL done_unexpected: done with id=%0d sum=%h cout=%0d, no op pending",
                   bus.done_id, bus.sum, bus.cout);
        end else begin
          logic [W+1:0] e;
          e = q.pop_front();
          if ({bus.done_id, bus.cout, bus.sum} !== e) begin
            bad++;
            $display("FAIL result: got id=%0d cout=%0d sum=%h, required id=%0d cout=%0d sum=%h",
                     bus.done_id, bus.cout, bus.sum, e[W+1], e[W], e[W-1:0]);
          end
        end
        total++;
        if (cyc - gnt_cyc != W) begin
          bad++;
          $display("FAIL latency: gnt-to-done %0d edges, required %0d", cyc - gnt_cyc, W);
        end
        if (spacing_on && last_done >= 0) begin
          total++;
          if (cyc - last_done != W + 2) begin
            bad++;
            $display("FAIL spacing: done-to-done %0d cycles, required %0d", cyc - last_done, W + 2);
          end
        end
        last_done = cyc;
      end
    end else begin
      prev_gnt = 1'b0;
    end
  end

  task automatic check_reset_outputs(input string nm);
    total++;
    if ({bus.gnt0, bus.gnt1, bus.busy, bus.done, bus.done_id, bus.cout} !== 6'b0 ||
        bus.sum !== '0) begin
      bad++;
      $display("FAIL %s: gnt0=%0d gnt1=%0d busy=%0d done=%0d id=%0d sum=%h cout=%0d, required all 0",
               nm, bus.gnt0, bus.gnt1, bus.busy, bus.done, bus.done_id, bus.sum, bus.cout);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("reset_async");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: %0d results pending, required 0", q.size());
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wait_gnt(input bit id);
    int n = 0;
    while (!(id ? bus.gnt1 : bus.gnt0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= 50) begin
      bad++;
      $display("FAIL gnt_timeout: gnt%0d not seen, required within 50 cycles", id);
    end
  endtask

  task automatic single_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic c, input logic [W+1:0] exp);
    q.push_back(exp);
    @(negedge clk);
    if (id) begin bus.a1 = a; bus.b1 = b; bus.cin1 = c; bus.req1 = 1'b1; end
    else    begin bus.a0 = a; bus.b0 = b; bus.cin0 = c; bus.req0 = 1'b1; end
    @(negedge clk);
    wait_gnt(id);
    if (id) bus.req1 = 1'b0; else bus.req0 = 1'b0;
    wait_drain();
  endtask

  // Both requesters held until each has received n grants; op k belongs to
  // requester k%2 and uses operands va/vb/vc[k].
  task automatic burst(input int n);
    int g0 = 0, g1 = 0, t = 0;
    last_done  = -1;
    spacing_on = 1;
    @(negedge clk);
    bus.a0 = va[0]; bus.b0 = vb[0]; bus.cin0 = vc[0];
    bus.a1 = va[1]; bus.b1 = vb[1]; bus.cin1 = vc[1];
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    while ((g0 < n || g1 < n) && t < 200) begin
      @(negedge clk);
      t++;
      if (bus.gnt0) begin
        g0++;
        if (g0 >= n) bus.req0 = 1'b0;
        else begin bus.a0 = va[2*g0]; bus.b0 = vb[2*g0]; bus.cin0 = vc[2*g0]; end
      end
      if (bus.gnt1) begin
        g1++;
        if (g1 >= n) bus.req1 = 1'b0;
        else begin bus.a1 = va[2*g1+1]; bus.b1 = vb[2*g1+1]; bus.cin1 = vc[2*g1+1]; end
      end
    end
    total++;
    if (t >= 200) begin
      bad++;
      $display("FAIL burst_timeout: grants g0=%0d g1=%0d, required %0d each", g0, g1, n);
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    wait_drain();
    spacing_on = 0;
  endtask

  initial begin
    bus.req0 = 1'b0; bus.a0 = '0; bus.b0 = '0; bus.cin0 = 1'b0;
    bus.req1 = 1'b0; bus.a1 = '0; bus.b1 = '0; bus.cin1 = 1'b0;
    #1 check_reset_outputs("reset_initial");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle with no requests: no grants, not busy.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (bus.gnt0 | bus.gnt1 | bus.busy) begin
        bad++;
        $display("FAIL idle_quiet: gnt0=%0d gnt1=%0d busy=%0d, required 0",
                 bus.gnt0, bus.gnt1, bus.busy);
      end
    end

    single_op(1'b0, 8'h3C, 8'h0F, 1'b0, 10'h04B);
    single_op(1'b1, 8'hFF, 8'h01, 1'b0, 10'h300);
    single_op(1'b1, 8'hFF, 8'hFF, 1'b1, 10'h3FF);

    // Contention right after reset: rr_ptr=0 so requester 0 goes first.
    apply_reset();
    va[0] = 8'h10; vb[0] = 8'h20; vc[0] = 1'b1;
    va[1] = 8'hF0; vb[1] = 8'h20; vc[1] = 1'b0;
    q.push_back(10'h031);
    q.push_back(10'h310);
    burst(1);

    // Fairness: two grants each, alternating 0,1,0,1.
    apply_reset();
    va[0] = 8'h01; vb[0] = 8'h02; vc[0] = 1'b0;
    va[1] = 8'h80; vb[1] = 8'h80; vc[1] = 1'b1;
    va[2] = 8'h55; vb[2] = 8'hAA; vc[2] = 1'b1;
    va[3] = 8'h7F; vb[3] = 8'h01; vc[3] = 1'b0;
    q.push_back(10'h003);
    q.push_back(10'h301);
    q.push_back(10'h100);
    q.push_back(10'h280);
    burst(2);

    // Reset on the 4th RUN cycle: op discarded, outputs cleared at once.
    @(negedge clk);
    bus.a0 = 8'h12; bus.b0 = 8'h34; bus.cin0 = 1'b0; bus.req0 = 1'b1;
    @(negedge clk);
    wait_gnt(1'b0);
    bus.req0 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("reset_midop");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (bus.busy | bus.done) begin
      bad++;
      $display("FAIL midop_discard: busy=%0d done=%0d after reset, required 0", bus.busy, bus.done);
    end
    single_op(1'b1, 8'h11, 8'h22, 1'b0, 10'h233);

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_left: %0d pending, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
